// File: rtl/mac_vec.sv
// Vector dot-product MAC: LANES multiplies per cycle over BEATS cycles, optional tiled accumulation.
// Define MAC_VEC_SAT_EN to clamp overflowing updates; otherwise the accumulator wraps.
module mac_vec #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int VEC_LEN    = 4,
  parameter int LANES      = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH*VEC_LEN-1:0]  row,
  input  logic [DATA_WIDTH*VEC_LEN-1:0]  col,
  input  logic                           is_signed,
  input  logic                           acc_keep,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ACC_WIDTH-1:0]           result,
  output logic                           overflow
);

  localparam int BEATS = VEC_LEN / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int SW    = ACC_WIDTH + $clog2(LANES) + 2;
  localparam int VW    = DATA_WIDTH * VEC_LEN;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

`ifdef MAC_VEC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [ACC_WIDTH-1:0]    result_q, result_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic                    ovf_q, ovf_d;
  logic [VW-1:0]           row_q, col_q;
  logic                    sgn_q;
  logic                    load;
  logic signed [SW-1:0]    beat_sum;
  logic [ACC_WIDTH-1:0]    acc_nxt;
  logic                    step_ovf;

  // Element 0 lives in the most-significant slice.
  function automatic logic [DATA_WIDTH-1:0] elem(input logic [VW-1:0] v, input int i);
    return v[(VEC_LEN-1-i)*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  function automatic logic signed [SW-1:0] lane_prod(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b,
                                                      input logic sgn);
    logic signed [PW-1:0] ps;
    logic [PW-1:0]        pu;
    ps = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) * $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
    pu = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    if (sgn) return {{(SW-PW){ps[PW-1]}}, ps};
    return {{(SW-PW){1'b0}}, pu};
  endfunction

  function automatic logic signed [SW-1:0] acc_ext(input logic [ACC_WIDTH-1:0] a, input logic sgn);
    if (sgn) return {{(SW-ACC_WIDTH){a[ACC_WIDTH-1]}}, a};
    return {{(SW-ACC_WIDTH){1'b0}}, a};
  endfunction

  // Signed: upper bits must all match the ACC sign bit. Unsigned: the sum is never negative.
  function automatic logic acc_ovf(input logic signed [SW-1:0] s, input logic sgn);
    if (sgn) return !((&s[SW-1:ACC_WIDTH-1]) || !(|s[SW-1:ACC_WIDTH-1]));
    return |s[SW-1:ACC_WIDTH];
  endfunction

  function automatic logic [ACC_WIDTH-1:0] acc_sat(input logic signed [SW-1:0] s,
                                                   input logic sgn, input logic ovf);
    logic [ACC_WIDTH-1:0] lim;
    if (!sgn)          lim = '1;
    else if (s[SW-1])  lim = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else               lim = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return (ovf && SAT_EN) ? lim : s[ACC_WIDTH-1:0];
  endfunction

  always_comb begin
    beat_sum = acc_ext(acc_q, sgn_q);
    for (int l = 0; l < LANES; l++) begin
      beat_sum = beat_sum + lane_prod(elem(row_q, int'(beat_q) * LANES + l),
                                      elem(col_q, int'(beat_q) * LANES + l), sgn_q);
    end
    step_ovf = acc_ovf(beat_sum, sgn_q);
    acc_nxt  = acc_sat(beat_sum, sgn_q, step_ovf);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    beat_d    = beat_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    load      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          acc_d   = acc_keep ? result_q : '0;
          ovf_d   = 1'b0;
          beat_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_nxt;
        ovf_d = ovf_q | step_ovf;
        if (beat_q == LAST_BEAT) begin
          result_d = acc_nxt;
          beat_d   = '0;
          state_d  = DONE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      result_q <= '0;
      beat_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      beat_q   <= beat_d;
      ovf_q    <= ovf_d;
    end
  end

  // Operand capture: only on accept, so inputs are ignored outside IDLE.
  always_ff @(posedge clk) begin
    if (load) begin
      row_q <= row;
      col_q <= col;
      sgn_q <= is_signed;
    end
  end

  assign result   = result_q;
  assign overflow = ovf_q;

endmodule
